// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants and types
// Purpose : widths, register-index/word types and the zero-register index
//           shared by the register file, ALU control and decode stages.
// Ports   : none (package).
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational register-file read port
// Purpose : selects one register, forces index 0 to zero and, when built with
//           REGFILE_BYPASS_EN, forwards the same-cycle write data.
// Ports   : rd_idx_i   - register index to read
//           regs_i     - current storage contents
//           wr_en_i    - an effective write is happening this cycle
//           wr_idx_i   - index being written
//           wr_data_i  - data being written
//           rd_data_o  - read data (combinational)
// Macro   : REGFILE_BYPASS_EN enables write-first forwarding.
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREGS  = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0] rd_idx_i,
    input  logic [DATA_W-1:0] regs_i [NREGS],
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic rd_zero;
    assign rd_zero = (rd_idx_i == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
    // wr_en_i already excludes index 0, so x0 can never be forwarded.
    logic fwd_hit;
    assign fwd_hit = wr_en_i && (wr_idx_i == rd_idx_i);

    always_comb begin
        rd_data_o = regs_i[rd_idx_i];
        if (rd_zero) begin
            rd_data_o = '0;
        end else if (fwd_hit) begin
            rd_data_o = wr_data_i;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_idx_i, wr_data_i};

    always_comb begin
        rd_data_o = regs_i[rd_idx_i];
        if (rd_zero) begin
            rd_data_o = '0;
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read one-write register file with write counter
// Purpose : architectural register storage for the single-cycle datapath;
//           x0 reads as zero and ignores writes; WrCount counts effective
//           writes and wraps.
// Ports   : clk, reset (async active-high)
//           RegWrite, WriteReg, WriteData - write port
//           ReadReg1/ReadData1, ReadReg2/ReadData2 - combinational read ports
//           WrCount - effective writes since reset
// Macro   : REGFILE_BYPASS_EN enables write-first forwarding on both ports.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [31:0]       WrCount
);

    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [31:0]       wr_count_q;
    logic [31:0]       wr_count_d;
    logic              wr_eff;
    logic              fwd_en;

    assign wr_eff = RegWrite && (WriteReg != ADDR_W'(REG_ZERO));

    // Reads must be zero while reset is held, so forwarding is gated too.
    assign fwd_en = wr_eff && !reset;

    assign wr_count_d = wr_eff ? (wr_count_q + 32'd1) : wr_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (wr_eff) begin
                regs_q[WriteReg] <= WriteData;
            end
            wr_count_q <= wr_count_d;
        end
    end

    assign WrCount = wr_count_q;

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rd1 (
        .rd_idx_i  (ReadReg1),
        .regs_i    (regs_q),
        .wr_en_i   (fwd_en),
        .wr_idx_i  (WriteReg),
        .wr_data_i (WriteData),
        .rd_data_o (ReadData1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rd2 (
        .rd_idx_i  (ReadReg2),
        .regs_i    (regs_q),
        .wr_en_i   (fwd_en),
        .wr_idx_i  (WriteReg),
        .wr_data_i (WriteData),
        .rd_data_o (ReadData2)
    );

endmodule
